// File: rtl/store_pkg.sv
// Shared types and constants for the store buffer: store-width encodings,
// the queued entry payload and the fence FSM state encoding.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int STRB_W = 4;

    // Payload of one queued store; the word address is held alongside it in
    // its own array so the address width can follow the top-level parameter.
    typedef struct packed {
        logic [31:0]       wdata;
        logic [STRB_W-1:0] wstrb;
    } sb_data_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FENCE = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_lane_align.sv
// Combinational lane steering for SB/SH/SW: replicates store data across byte
// lanes, builds the byte strobe and flags misaligned or illegal stores.
module sb_lane_align
    import store_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic [31:0]       data,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              illegal
);

    always_comb begin
        wdata   = '0;
        wstrb   = '0;
        illegal = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            F3_SH: begin
                wdata   = {2{data[15:0]}};
                wstrb   = 4'b0011 << addr_lo;
                illegal = addr_lo[0];
            end
            F3_SW: begin
                wdata   = data;
                wstrb   = 4'b1111;
                illegal = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns core stores, queues them in a DEPTH-entry FIFO, drains
// them over a valid/ready write port, flags load RAW hazards and handles fence
// drains. Define STORE_FWD_EN to forward full-word stores to hitting loads.
// Store port: a store is taken on any cycle with st_valid && st_ready; memory
// port: the head is retired on any cycle with mem_valid && mem_ready, and
// mem_* hold steady while mem_valid && !mem_ready.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_err,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_stall,
    output logic                       ld_fwd_valid,
    output logic [31:0]                ld_fwd_data,
    input  logic                       fence_req,
    output logic                       fence_ack,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [STRB_W-1:0]          mem_wstrb,
    output logic [$clog2(DEPTH):0]     count,
    output sb_state_e                  state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_state_e          state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               st_err_q, st_err_d;
    logic               fence_ack_q, fence_ack_d;

    logic [ADDR_W-3:0]  addr_mem_q [DEPTH];
    sb_data_t           data_mem_q [DEPTH];

    logic [31:0]        al_wdata;
    logic [STRB_W-1:0]  al_wstrb;
    logic               al_illegal;
    logic               st_acc, push, pop, match;
    logic [PTR_W-1:0]   idx;
`ifdef STORE_FWD_EN
    logic               fwd_full;
    logic [31:0]        fwd_data;
`endif

    sb_lane_align u_align (
        .addr_lo (st_addr[1:0]),
        .funct3  (st_funct3),
        .data    (st_data),
        .wdata   (al_wdata),
        .wstrb   (al_wstrb),
        .illegal (al_illegal)
    );

    assign st_ready  = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
    assign st_acc    = st_valid && st_ready;
    assign push      = st_acc && !al_illegal;
    assign mem_valid = (count_q != '0);
    assign pop       = mem_valid && mem_ready;

    assign mem_addr  = {addr_mem_q[rd_ptr_q], 2'b00};
    assign mem_wdata = data_mem_q[rd_ptr_q].wdata;
    assign mem_wstrb = data_mem_q[rd_ptr_q].wstrb;
    assign count     = count_q;
    assign st_err    = st_err_q;
    assign fence_ack = fence_ack_q;
    assign state_dbg = state_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        st_err_d = st_acc && al_illegal;
    end

    // An empty buffer with no store arriving acknowledges a fence without
    // passing through FENCE, so the ack lands on the following cycle.
    always_comb begin
        state_d     = state_q;
        fence_ack_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fence_req) begin
                    if (count_q == '0 && !push) fence_ack_d = 1'b1;
                    else                        state_d     = ST_FENCE;
                end
            end
            ST_FENCE: begin
                if (count_q == '0) begin
                    state_d     = ST_RUN;
                    fence_ack_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            st_err_q    <= 1'b0;
            fence_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            st_err_q    <= st_err_d;
            fence_ack_q <= fence_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= st_addr[ADDR_W-1:2];
            data_mem_q[wr_ptr_q] <= '{wdata: al_wdata, wstrb: al_wstrb};
        end
    end

    // Walk entries oldest to youngest so the last hit is the youngest store.
    always_comb begin
        match = 1'b0;
        idx   = rd_ptr_q;
`ifdef STORE_FWD_EN
        fwd_full = 1'b0;
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q && addr_mem_q[idx] == ld_addr[ADDR_W-1:2]) begin
                match = 1'b1;
`ifdef STORE_FWD_EN
                fwd_full = (data_mem_q[idx].wstrb == 4'b1111);
                fwd_data = data_mem_q[idx].wdata;
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_stall     = ld_valid && match && !fwd_full;
    assign ld_fwd_valid = ld_valid && match && fwd_full;
    assign ld_fwd_data  = ld_fwd_valid ? fwd_data : 32'h0;
`else
    assign ld_stall     = ld_valid && match;
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'h0;
`endif

endmodule
